// File: rtl/sram1_arbiter_if.sv
// rtl/sram1_arbiter_if.sv - request/response and memory-port bundle for sram1_arbiter
//
// Purpose: groups the two requester ports, the status output and the single
// SRAM 1 memory port so the arbiter and its environment share one connection.
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requests, held until ack
//   ack0/ack1, err0/err1, rdata0/rdata1            : one-cycle completion per port
//   busy                                           : arbiter not in IDLE
//   mem_address, mem_data_in, mem_read_write       : access to SRAM 1
//   mem_data_out                                   : SRAM 1 read data
// Modports: slave = arbiter side, master = requesters plus memory side.

interface sram1_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic        ack0;
   logic        ack1;
   logic        err0;
   logic        err1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;
   logic        busy;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_read_write;
   logic [31:0] mem_data_out;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
      output ack0, ack1, err0, err1, rdata0, rdata1, busy,
             mem_address, mem_data_in, mem_read_write
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
      input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
             mem_address, mem_data_in, mem_read_write
   );
endinterface

// File: rtl/sram1_arbiter.sv
// rtl/sram1_arbiter.sv - two-port round-robin arbiter and sequencer for SRAM 1
//
// Purpose: decodes the SRAM 1 window, serialises port 0 (fetch) and port 1
// (load/store) accesses onto the single memory port and returns a one-cycle
// acknowledge with read data. Out-of-window requests get an error acknowledge
// without touching memory.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sram1_arbiter_if.slave (requests, responses, busy, memory port)
// Every output is a flop; there is no combinational input-to-output path.

module sram1_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter logic [31:0] LAST_ADDR = 32'h2001_7FFF,
   parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
   input logic           clock,
   input logic           reset,
   sram1_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      ACK     = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err0_q, err0_d;
   logic        err1_q, err1_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        busy_q, busy_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_data_in_q, mem_data_in_d;
   logic        mem_read_write_q, mem_read_write_d;

   logic        gnt;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   function automatic logic in_window(input logic [31:0] a);
      return (a >= BASE_ADDR) && (a <= LAST_ADDR);
   endfunction

   always_comb begin
      state_d          = state_q;
      prio_d           = prio_q;
      port_d           = port_q;
      we_d             = we_q;
      ack0_d           = 1'b0;
      ack1_d           = 1'b0;
      err0_d           = 1'b0;
      err1_d           = 1'b0;
      rdata0_d         = rdata0_q;
      rdata1_d         = rdata1_q;
      mem_address_d    = IDLE_ADDR;
      mem_data_in_d    = 32'h0;
      mem_read_write_d = 1'b0;

      // A lone requester wins outright; a tie goes to the priority bit.
      gnt       = (bus.req0 && bus.req1) ? prio_q : bus.req1;
      sel_we    = gnt ? bus.we1    : bus.we0;
      sel_addr  = gnt ? bus.addr1  : bus.addr0;
      sel_wdata = gnt ? bus.wdata1 : bus.wdata0;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               port_d = gnt;
               we_d   = sel_we;
               prio_d = ~gnt;
               if (in_window(sel_addr)) begin
                  // Memory-port flops are loaded here so they are stable for
                  // the whole ACCESS cycle; they hold the latched request.
                  state_d          = ACCESS;
                  mem_address_d    = sel_addr;
                  mem_data_in_d    = sel_wdata;
                  mem_read_write_d = sel_we;
               end else begin
                  state_d = ACK;
                  if (gnt) begin
                     ack1_d   = 1'b1;
                     err1_d   = 1'b1;
                     rdata1_d = 32'h0;
                  end else begin
                     ack0_d   = 1'b1;
                     err0_d   = 1'b1;
                     rdata0_d = 32'h0;
                  end
               end
            end
         end
         ACCESS: begin
            if (we_q) begin
               state_d = ACK;
               if (port_q) begin
                  ack1_d   = 1'b1;
                  rdata1_d = 32'h0;
               end else begin
                  ack0_d   = 1'b1;
                  rdata0_d = 32'h0;
               end
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // Memory presents read data during this cycle; capture it
            // straight into the granted port's rdata flop.
            state_d = ACK;
            if (port_q) begin
               ack1_d   = 1'b1;
               rdata1_d = bus.mem_data_out;
            end else begin
               ack0_d   = 1'b1;
               rdata0_d = bus.mem_data_out;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= IDLE;
         prio_q           <= 1'b0;
         port_q           <= 1'b0;
         we_q             <= 1'b0;
         ack0_q           <= 1'b0;
         ack1_q           <= 1'b0;
         err0_q           <= 1'b0;
         err1_q           <= 1'b0;
         rdata0_q         <= 32'h0;
         rdata1_q         <= 32'h0;
         busy_q           <= 1'b0;
         mem_address_q    <= IDLE_ADDR;
         mem_data_in_q    <= 32'h0;
         mem_read_write_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         prio_q           <= prio_d;
         port_q           <= port_d;
         we_q             <= we_d;
         ack0_q           <= ack0_d;
         ack1_q           <= ack1_d;
         err0_q           <= err0_d;
         err1_q           <= err1_d;
         rdata0_q         <= rdata0_d;
         rdata1_q         <= rdata1_d;
         busy_q           <= busy_d;
         mem_address_q    <= mem_address_d;
         mem_data_in_q    <= mem_data_in_d;
         mem_read_write_q <= mem_read_write_d;
      end
   end

   assign bus.ack0           = ack0_q;
   assign bus.ack1           = ack1_q;
   assign bus.err0           = err0_q;
   assign bus.err1           = err1_q;
   assign bus.rdata0         = rdata0_q;
   assign bus.rdata1         = rdata1_q;
   assign bus.busy           = busy_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_data_in    = mem_data_in_q;
   assign bus.mem_read_write = mem_read_write_q;

endmodule

// File: tb/tb_sram1_arbiter.sv
// tb/tb_sram1_arbiter.sv - scoreboard testbench for sram1_arbiter

module tb_sram1_arbiter;

   localparam logic [31:0] WIN_LO = 32'h2000_0000;
   localparam logic [31:0] WIN_HI = 32'h2001_7FFF;

   logic clock = 1'b0;
   logic reset;

   sram1_arbiter_if bus ();

   sram1_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural SRAM 1 on the memory port.
   logic [31:0] sram_mem [logic [31:0]];
   logic [31:0] ref_mem  [logic [31:0]];

   function automatic logic [31:0] fill(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clock) begin
      if (bus.mem_read_write)
         sram_mem[bus.mem_address] = bus.mem_data_in;
      else
         bus.mem_data_out <= sram_mem.exists(bus.mem_address) ?
                             sram_mem[bus.mem_address] : fill(bus.mem_address);
   end

   // Scoreboard: one expectation queue per port, popped on ack.
   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   grant_log[$];
   int   cyc = 0;
   int   ack_cyc0 = 0;
   int   ack_cyc1 = 0;
   int   ack_cnt0 = 0;
   int   ack_cnt1 = 0;
   int   mem_nz = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      exp_t e;
      if (bus.mem_address != 32'h0) mem_nz++;
      if (bus.ack0 || bus.ack1) check_eq("ack_exclusive", {31'h0, bus.ack0 & bus.ack1}, 32'h0);
      if (bus.ack0) begin
         ack_cnt0++;
         ack_cyc0 = cyc;
         grant_log.push_back(0);
         check_eq("ack0_expected", {31'h0, q0.size() != 0}, 32'h1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check_eq("err0", {31'h0, bus.err0}, {31'h0, e.err});
            check_eq("rdata0", bus.rdata0, e.rdata);
         end
      end
      if (bus.ack1) begin
         ack_cnt1++;
         ack_cyc1 = cyc;
         grant_log.push_back(1);
         check_eq("ack1_expected", {31'h0, q1.size() != 0}, 32'h1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check_eq("err1", {31'h0, bus.err1}, {31'h0, e.err});
            check_eq("rdata1", bus.rdata1, e.rdata);
         end
         if (!bus.ack0) check_eq("err0_quiet", {31'h0, bus.err0}, 32'h0);
      end
   end

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   task automatic expect_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      e.err   = !((a >= WIN_LO) && (a <= WIN_HI));
      e.rdata = (e.err || we) ? 32'h0 : ref_read(a);
      if (!e.err && we) ref_mem[a] = wd;
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
      end else begin
         bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
      end
   endtask

   // Raises a request, waits (bounded) for its ack, then drops req in the
   // following cycle. Latency counts from the cycle req is first high.
   task automatic port_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input int exp_lat, input string tag, output int lat);
      int n;
      bit seen;
      expect_txn(p, we, a, wd);
      drive(p, 1'b1, we, a, wd);
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(negedge clock);
         n++;
         seen = (p == 0) ? bus.ack0 : bus.ack1;
      end
      lat = n - 1;
      check_eq({tag, "_ack_seen"}, {31'h0, seen}, 32'h1);
      if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
      @(posedge clock); #2;
      drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic gap();
      @(posedge clock); #2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   int n;
   int lat;
   int lat2;
   int c0;
   int nz0;
   int gl_start;

   initial begin
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      check_eq("rst_ack0", {31'h0, bus.ack0}, 32'h0);
      check_eq("rst_ack1", {31'h0, bus.ack1}, 32'h0);
      check_eq("rst_err0", {31'h0, bus.err0}, 32'h0);
      check_eq("rst_err1", {31'h0, bus.err1}, 32'h0);
      check_eq("rst_rdata0", bus.rdata0, 32'h0);
      check_eq("rst_rdata1", bus.rdata1, 32'h0);
      check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
      check_eq("rst_mem_addr", bus.mem_address, 32'h0);
      check_eq("rst_mem_rw", {31'h0, bus.mem_read_write}, 32'h0);
      check_eq("rst_mem_din", bus.mem_data_in, 32'h0);

      // Reset held two cycles starting in CAPTURE of a port 0 read.
      gap();
      c0 = ack_cnt0;
      drive(0, 1'b1, 1'b0, 32'h2000_0040, 32'h0);
      n = 0;
      while (bus.mem_address != 32'h2000_0040 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check_eq("abort_access_seen", bus.mem_address, 32'h2000_0040);
      @(posedge clock); #2;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      check_eq("abort_ack0", {31'h0, bus.ack0}, 32'h0);
      check_eq("abort_busy", {31'h0, bus.busy}, 32'h0);
      check_eq("abort_mem_addr", bus.mem_address, 32'h0);
      repeat (10) @(negedge clock);
      check_eq("abort_no_ack", ack_cnt0 - c0, 32'h0);

      // Contention: both ports hold requests, re-raise one cycle after drop.
      gap();
      gl_start = grant_log.size();
      fork
         begin
            int l0;
            for (int i = 0; i < 3; i++) begin
               port_txn(0, 1'b1, 32'h2000_0200 + i * 4, 32'h1111_0000 + i, -1, "cont0", l0);
               check_eq("cont0_wait_bound", {31'h0, l0 <= 5}, 32'h1);
               gap();
            end
         end
         begin
            int l1;
            for (int j = 0; j < 3; j++) begin
               port_txn(1, 1'b1, 32'h2000_0300 + j * 4, 32'h2222_0000 + j, -1, "cont1", l1);
               check_eq("cont1_wait_bound", {31'h0, l1 <= 5}, 32'h1);
               gap();
            end
         end
      join
      check_eq("cont_grant_count", grant_log.size() - gl_start, 32'd6);
      for (int k = 0; k < 6; k++)
         if (gl_start + k < grant_log.size())
            check_eq("cont_grant_order", grant_log[gl_start + k], k % 2);

      // Single write then read on port 1.
      gap();
      port_txn(1, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 2, "wr1", lat);
      gap();
      port_txn(1, 1'b0, 32'h2000_0010, 32'h0, 3, "rd1", lat);
      gap();
      port_txn(0, 1'b0, 32'h2000_0200, 32'h0, 3, "rd0_back", lat);

      // Window edges.
      gap();
      port_txn(0, 1'b0, 32'h2001_7FFF, 32'h0, 3, "rd_last", lat);
      gap();
      port_txn(1, 1'b0, 32'h2000_0000, 32'h0, 3, "rd_first", lat);
      gap();
      nz0 = mem_nz;
      port_txn(0, 1'b0, 32'h2001_8000, 32'h0, 1, "rd_past", lat);
      gap();
      port_txn(1, 1'b0, 32'h1FFF_FFFC, 32'h0, 1, "rd_below", lat);
      gap();
      port_txn(1, 1'b1, 32'hFFFF_FFF0, 32'h1234_5678, 1, "wr_high", lat);
      check_eq("err_no_mem_access", mem_nz - nz0, 32'h0);

      // Late request: port 1 rises during port 0's ACCESS.
      gap();
      fork
         port_txn(0, 1'b1, 32'h2000_0100, 32'hCAFE_0001, 2, "late0", lat);
         begin
            int m;
            m = 0;
            while (bus.mem_address != 32'h2000_0100 && m < 20) begin
               @(negedge clock);
               m++;
            end
            check_eq("late_access_seen", bus.mem_address, 32'h2000_0100);
            port_txn(1, 1'b1, 32'h2000_0104, 32'hCAFE_0002, -1, "late1", lat2);
         end
      join
      check_eq("late_ack_gap", ack_cyc1 - ack_cyc0, 32'd3);
      gap();
      port_txn(0, 1'b0, 32'h2000_0104, 32'h0, 3, "late_rdback", lat);

      // Hold violation: req kept high for the IDLE cycle after ack.
      gap();
      c0 = ack_cnt0;
      expect_txn(0, 1'b1, 32'h2000_0400, 32'h0BAD_F00D);
      expect_txn(0, 1'b1, 32'h2000_0400, 32'h0BAD_F00D);
      drive(0, 1'b1, 1'b1, 32'h2000_0400, 32'h0BAD_F00D);
      n = 0;
      while (!bus.ack0 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check_eq("hold_first_ack", {31'h0, bus.ack0}, 32'h1);
      @(posedge clock); #2;
      @(posedge clock); #2;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (8) @(negedge clock);
      check_eq("hold_extra_ack", ack_cnt0 - c0, 32'd2);

      check_eq("q0_drained", q0.size(), 32'h0);
      check_eq("q1_drained", q1.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram1_arbiter.md
# sram1_arbiter

Two-port round-robin arbiter and sequencer in front of the SRAM 1 block (96 KB, 0x2000_0000–0x2001_7FFF). Port 0 serves instruction fetch and port 1 serves the load/store unit. The block decodes the SRAM 1 address window, serialises accesses, drives the single memory port, and returns read data with a one-cycle acknowledge pulse. Out-of-window requests are answered with an error acknowledge and never reach memory.

## Interface
Parameters:
- BASE_ADDR, 32'h2000_0000, first byte of the SRAM 1 window
- LAST_ADDR, 32'h2001_7FFF, last byte of the SRAM 1 window (inclusive)
- IDLE_ADDR, 32'h0000_0000, address driven to memory when no access is in progress; lies outside the window

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  request from port 0 / port 1; held stable until ack
- we0 / we1  in  1  1 = write, 0 = read; held with req
- addr0 / addr1  in  32  request address; held with req
- wdata0 / wdata1  in  32  write data; held with req
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack; 1 = address outside the window
- rdata0 / rdata1  out  32  read data, valid while ack is high
- busy  out  1  high in every state except IDLE
- mem_address  out  32  address to SRAM 1
- mem_data_in  out  32  write data to SRAM 1
- mem_read_write  out  1  1 = write, 0 = read
- mem_data_out  in  32  read data from SRAM 1, valid in the cycle after the access cycle

## Operation
- States: IDLE, ACCESS, CAPTURE, ACK.
- IDLE: if any req is high, select the port, latch its we, addr and wdata into internal registers, and record the port.
  - Address in window (BASE_ADDR ≤ addr ≤ LAST_ADDR, unsigned 32-bit compares): go to ACCESS.
  - Address outside the window: go to ACK with err = 1, rdata = 0.
- ACCESS (one cycle): drive mem_address, mem_data_in and mem_read_write from the latched request. Memory performs the operation on the rising edge that ends this cycle.
  - Write: next state is ACK.
  - Read: next state is CAPTURE.
- CAPTURE (one cycle): mem_address returns to IDLE_ADDR and mem_read_write to 0. mem_data_out is registered on the edge ending this cycle. Next state is ACK.
- ACK (one cycle): ack and err are high for the granted port only. rdata holds the captured word for reads and 0 for writes and errors. Next state is IDLE.
- The other port's ack and err stay 0. Its rdata holds its last value.
- Outside ACCESS: mem_address = IDLE_ADDR, mem_read_write = 0, mem_data_in = 0. These are registered outputs, so they are glitch-free.
- Arbitration: a round-robin priority bit, which is 0 after reset.
  - If only one req is high, that port is granted.
  - If both are high, the port named by the priority bit is granted.
  - After any grant, including an error grant, the priority bit points to the other port.
- Requests are sampled only in IDLE. A req that arrives or changes during ACCESS, CAPTURE or ACK is ignored until the next IDLE.
- A requester must drop req in the cycle after ack. A req still high in the following IDLE cycle is a new request.
- Reset, at any cycle including mid-transaction:
  - Control: state = IDLE; priority = 0; busy = 0.
  - Port outputs: all ack, err and rdata = 0.
  - Memory outputs: mem_address = IDLE_ADDR, mem_read_write = 0, mem_data_in = 0.
  - The aborted transaction is never acknowledged. A write that was in ACCESS during the reset edge may or may not have completed.

## Timing
- Latency is measured from the IDLE cycle T in which req is sampled:
  - Write: ACCESS in T+1, ack in T+2.
  - Read: ACCESS in T+1, CAPTURE in T+2, ack and rdata in T+3.
  - Error: ack and err in T+1.
- Back-to-back requests: the next IDLE is the cycle after ACK. Peak throughput is one write per 3 cycles or one read per 4 cycles.
- With both ports requesting continuously, grants alternate 0,1,0,1… starting with port 0 after reset.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan
- Reset: hold reset for 2 cycles mid-read (state CAPTURE) → next cycle all ack = 0, busy = 0, mem_address = 0x0000_0000, and no ack ever arrives for the aborted read.
- Single write then read: port 1 writes 0xDEAD_BEEF to 0x2000_0010, then reads the same address → ack1 at T+2 for the write; ack1 at T+3 for the read with rdata1 = 0xDEAD_BEEF and err1 = 0.
- Window edges: read 0x2001_7FFF → normal access. Read 0x2001_8000 and 0x1FFF_FFFC → ack with err = 1, rdata = 0, and mem_address stays 0x0000_0000 throughout.
- Contention: req0 and req1 asserted together and held, each dropped after its ack and re-raised 1 cycle later → grants alternate 0,1,0,1 and neither port waits more than one foreign transaction.
- Late request: req1 rises during port 0's ACCESS → port 1 is ignored until IDLE, granted in the IDLE cycle after ack0, and receives ack1 at that IDLE cycle +2 for a write.
- Hold violation check: a requester keeps req high for one cycle after ack → the request is treated as a new transaction, and the bench asserts that exactly one extra ack is produced.
